// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer slice.
//   seq_state_e      : run-control FSM states
//   DEFAULT_RESET_PC : PC loaded on reset and on restart from HALT
//   DEFAULT_END_PC   : first PC past the program; reaching it halts
//   PC_ALIGN_MASK    : low PC bits that must be zero for a legal fetch
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALT
  } seq_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_END_PC   = 32'h0000_0100;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'h0000_0003;

endpackage

// File: rtl/pc_sequencer_retire_counter.sv
// Saturating retired-instruction counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : add one this cycle (ignored once all-ones)
//   clr          : synchronous clear, wins over inc
//   count        : current count
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and run-control stage ahead of the single-cycle datapath.
// Owns the PC, accepts the datapath's next_pc, and gates commit through an
// IDLE/RUN/STEP/HALT state machine.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start/step/stop  : run-control levels
//   next_pc          : PC+4 from the datapath adder
//   pc               : current fetch address
//   commit           : qualifies datapath RegWrite this cycle
//   halted/align_err : sticky status flags
//   retired          : saturating count of committed instructions
// Optional (macro PC_BREAKPOINT_EN): bp_addr, bp_valid inputs, bp_hit output.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] END_PC   = DEFAULT_END_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [31:0]      next_pc,
  output logic [31:0]      pc,
  output logic             commit,
  output logic             halted,
  output logic             align_err,
  output logic [CNT_W-1:0] retired
`ifdef PC_BREAKPOINT_EN
  ,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit
`endif
);

  seq_state_e  state, state_next;
  logic [31:0] pc_next;
  logic        halt_set;
  logic        align_set;
  logic        flags_clr;
  logic        cnt_clr;

`ifdef PC_BREAKPOINT_EN
  // first_run marks the first RUN cycle after leaving IDLE so a resume
  // from a breakpoint executes the trapping instruction instead of re-trapping.
  logic first_run, first_run_next;
  logic bp_set, bp_clr;
  logic bp_trap;
  assign bp_trap = bp_valid && (pc == bp_addr) && !first_run;
`endif

  always_comb begin
    state_next = state;
    pc_next    = pc;
    commit     = 1'b0;
    halt_set   = 1'b0;
    align_set  = 1'b0;
    flags_clr  = 1'b0;
    cnt_clr    = 1'b0;
`ifdef PC_BREAKPOINT_EN
    first_run_next = 1'b0;
    bp_set         = 1'b0;
    bp_clr         = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
`ifdef PC_BREAKPOINT_EN
          first_run_next = 1'b1;
          bp_clr         = 1'b1;
`endif
        end else if (step) begin
          state_next = ST_STEP;
`ifdef PC_BREAKPOINT_EN
          bp_clr = 1'b1;
`endif
        end
      end
      ST_RUN, ST_STEP: begin
        commit = 1'b1;
`ifdef PC_BREAKPOINT_EN
        if ((state == ST_RUN) && bp_trap) begin
          commit     = 1'b0;
          bp_set     = 1'b1;
          state_next = ST_IDLE;
        end
`endif
        if (commit) begin
          if ((next_pc & PC_ALIGN_MASK) != '0) begin
            align_set  = 1'b1;
            halt_set   = 1'b1;
            state_next = ST_HALT;
          end else if (next_pc >= END_PC) begin
            pc_next    = next_pc;
            halt_set   = 1'b1;
            state_next = ST_HALT;
          end else begin
            pc_next = next_pc;
            if ((state == ST_STEP) || stop) begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          pc_next    = RESET_PC;
          cnt_clr    = 1'b1;
          flags_clr  = 1'b1;
          state_next = ST_RUN;
`ifdef PC_BREAKPOINT_EN
          bp_clr = 1'b1;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      halted    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (flags_clr) begin
        halted    <= 1'b0;
        align_err <= 1'b0;
      end else begin
        if (halt_set)  halted    <= 1'b1;
        if (align_set) align_err <= 1'b1;
      end
    end
  end

`ifdef PC_BREAKPOINT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_run <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      first_run <= first_run_next;
      if (bp_clr)      bp_hit <= 1'b0;
      else if (bp_set) bp_hit <= 1'b1;
    end
  end
`endif

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (commit),
    .clr     (cnt_clr),
    .count   (retired)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, step, stop;
  logic [31:0] next_pc;
  logic [31:0] pc;
  logic        commit, halted, align_err;
  logic [31:0] retired;
  logic        force_en;
  logic [31:0] force_val;
`ifdef PC_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;
`endif

  logic       sat_inc, sat_clr;
  logic [2:0] sat_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  // datapath adder stand-in, overridable to inject bad next_pc values
  assign next_pc = force_en ? force_val : pc + 32'd4;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .END_PC   (32'h0000_0100),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .step      (step),
    .stop      (stop),
    .next_pc   (next_pc),
    .pc        (pc),
    .commit    (commit),
    .halted    (halted),
    .align_err (align_err),
    .retired   (retired)
`ifdef PC_BREAKPOINT_EN
    ,
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .bp_hit    (bp_hit)
`endif
  );

  retire_counter #(.CNT_W(3)) u_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sat_inc),
    .clr     (sat_clr),
    .count   (sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0;
    force_en = 1'b0; force_val = '0;
    sat_inc = 1'b0; sat_clr = 1'b0;
`ifdef PC_BREAKPOINT_EN
    bp_addr = '0; bp_valid = 1'b0;
`endif
    #12;
    check("rst_pc", pc, 0);
    check("rst_commit", commit, 0);
    check("rst_halted", halted, 0);
    check("rst_align", align_err, 0);
    check("rst_retired", retired, 0);
    reset_n = 1'b1;

    // start: commit in the next cycle, pc advances one edge later
    start = 1'b1; tick(); start = 1'b0;
    check("run0_commit", commit, 1);
    check("run0_pc", pc, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("run_pc", pc, 64'(4 * k));
    end
    check("run_retired", retired, 5);

    // stop: the stop cycle still commits, then IDLE holds
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_pc", pc, 32'h18);
    check("stop_commit", commit, 0);
    check("stop_retired", retired, 6);
    tick();
    check("idle_hold_pc", pc, 32'h18);

    // single step
    step = 1'b1; tick(); step = 1'b0;
    check("step_commit", commit, 1);
    check("step_pc", pc, 32'h18);
    tick();
    check("step_done_pc", pc, 32'h1C);
    check("step_done_commit", commit, 0);
    check("step_retired", retired, 7);

    // step held: STEP and IDLE alternate
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("step_held_commit", commit, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    step = 1'b0;
    check("step_held_pc", pc, 32'h24);
    check("step_held_retired", retired, 9);

    // misaligned next_pc halts with pc held, instruction still retires
    start = 1'b1; tick(); start = 1'b0;
    force_en = 1'b1; force_val = 32'h26;
    tick();
    check("align_pc", pc, 32'h24);
    check("align_err", align_err, 1);
    check("align_halted", halted, 1);
    check("align_retired", retired, 10);
    check("align_commit", commit, 0);
    step = 1'b1; stop = 1'b1; tick(); tick(); step = 1'b0; stop = 1'b0;
    check("halt_ign_commit", commit, 0);
    check("halt_ign_pc", pc, 32'h24);
    check("halt_ign_retired", retired, 10);

    // restart from HALT
    start = 1'b1; tick(); start = 1'b0; force_en = 1'b0;
    check("restart_pc", pc, 0);
    check("restart_retired", retired, 0);
    check("restart_halted", halted, 0);
    check("restart_align", align_err, 0);
    check("restart_commit", commit, 1);

    // run to END_PC, with stop coinciding with the halting cycle
    repeat (63) tick();
    check("pre_end_pc", pc, 32'hFC);
    check("pre_end_retired", retired, 63);
    stop = 1'b1; tick(); stop = 1'b0;
    check("end_pc", pc, 32'h100);
    check("end_halted", halted, 1);
    check("end_retired", retired, 64);
    check("end_commit", commit, 0);
    step = 1'b1; tick(); tick(); step = 1'b0;
    check("end_step_ign_commit", commit, 0);
    check("end_step_ign_pc", pc, 32'h100);

    // asynchronous reset in the middle of RUN
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_pc", pc, 8);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 0);
    check("async_rst_commit", commit, 0);
    check("async_rst_retired", retired, 0);
    check("async_rst_halted", halted, 0);

    // saturation on a narrow counter
    #3 reset_n = 1'b1;
    tick();
    sat_inc = 1'b1;
    repeat (9) tick();
    check("sat_count", sat_cnt, 7);
    sat_clr = 1'b1; tick(); sat_clr = 1'b0; sat_inc = 1'b0;
    check("sat_clr", sat_cnt, 0);

`ifdef PC_BREAKPOINT_EN
    bp_addr = 32'hC; bp_valid = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("bp_commit", commit, 0);
    check("bp_pc", pc, 32'hC);
    check("bp_retired", retired, 3);
    tick();
    check("bp_hit", bp_hit, 1);
    check("bp_hold_pc", pc, 32'hC);
    start = 1'b1; tick(); start = 1'b0;
    check("bp_resume_commit", commit, 1);
    check("bp_hit_clr", bp_hit, 0);
    tick();
    check("bp_resume_pc", pc, 32'h10);
    check("bp_resume_retired", retired, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
